// File: rtl/seven_seg_scanner_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seven_seg_scanner_pkg : segment codes, digit slots and blink fields.    |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
package seven_seg_scanner_pkg;

    // Active-low segment patterns, bit order a..g from MSB to LSB
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] DIGIT_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIGIT_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIGIT_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIGIT_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIGIT_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIGIT_HOUR_TENS = 3'd5;

    localparam logic [1:0] BLINK_SEC  = 2'd0;
    localparam logic [1:0] BLINK_MIN  = 2'd1;
    localparam logic [1:0] BLINK_HOUR = 2'd2;

    function automatic logic [1:0] blink_field(input logic [2:0] index);
        logic [1:0] field;
        field = BLINK_SEC;
        case (index)
            DIGIT_MIN_ONES, DIGIT_MIN_TENS:   field = BLINK_MIN;
            DIGIT_HOUR_ONES, DIGIT_HOUR_TENS: field = BLINK_HOUR;
            default:                          field = BLINK_SEC;
        endcase
        return field;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | bcd_to_seg : BCD nibble to active-low segments, blank above 9.          |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module bcd_to_seg
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seven_seg_scanner : 6-digit multiplexed HH:MM:SS display driver.        |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] hourBcd,
    input  logic [7:0] minBcd,
    input  logic [7:0] secBcd,
    input  logic [2:0] blinkMask,
    input  logic       blankLeadZero,
    output logic [5:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       digit_idx;
    logic [FRM_W-1:0] frame_cnt;
    logic             blink_phase;
    logic             load_pending;
    logic [7:0]       hour_sh;
    logic [7:0]       min_sh;
    logic [7:0]       sec_sh;

    logic             tick;
    logic             frame_wrap;
    logic             shadow_load;
    logic [3:0]       nibble;
    logic [6:0]       digit_seg;
    logic             force_blank;
    logic [5:0]       anode_next;
    logic             dp_next;

    assign tick        = enable && (prescaler == PRE_MAX);
    assign frame_wrap  = tick && (digit_idx == DIGIT_HOUR_TENS);
    assign shadow_load = enable && (load_pending || frame_wrap);

    always_comb begin
        nibble = sec_sh[3:0];
        case (digit_idx)
            DIGIT_SEC_ONES:  nibble = sec_sh[3:0];
            DIGIT_SEC_TENS:  nibble = sec_sh[7:4];
            DIGIT_MIN_ONES:  nibble = min_sh[3:0];
            DIGIT_MIN_TENS:  nibble = min_sh[7:4];
            DIGIT_HOUR_ONES: nibble = hour_sh[3:0];
            DIGIT_HOUR_TENS: nibble = hour_sh[7:4];
            default:         nibble = sec_sh[3:0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (nibble),
        .seg    (digit_seg)
    );

    // Blink mask and lead-zero enable act live; only the digit values are shadowed
    always_comb begin
        force_blank = (blink_phase && blinkMask[blink_field(digit_idx)])
                   || ((digit_idx == DIGIT_HOUR_TENS) && blankLeadZero
                       && (hour_sh[7:4] == 4'd0));
        anode_next  = ~(6'b000001 << digit_idx);
        dp_next     = ~(((digit_idx == DIGIT_MIN_ONES) || (digit_idx == DIGIT_HOUR_ONES))
                       && !blink_phase);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler    <= '0;
            digit_idx    <= DIGIT_SEC_ONES;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            load_pending <= 1'b1;
            hour_sh      <= 8'h00;
            min_sh       <= 8'h00;
            sec_sh       <= 8'h00;
            anode        <= 6'b111111;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
        end else if (enable) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == DIGIT_HOUR_TENS) ? DIGIT_SEC_ONES
                                                            : digit_idx + 3'd1;
            end
            if (frame_wrap) begin
                if (frame_cnt == FRM_MAX) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            if (shadow_load) begin
                hour_sh      <= hourBcd;
                min_sh       <= minBcd;
                sec_sh       <= secBcd;
                load_pending <= 1'b0;
            end
            anode <= anode_next;
            seg   <= force_blank ? SEG_BLANK : digit_seg;
            dp    <= dp_next;
        end
    end

endmodule
`default_nettype wire
